// File: rtl/priority_egress_scheduler.sv
// Four-class strict-priority egress scheduler: per-class beat FIFOs on ingress,
// packet-atomic selection of the highest non-empty class, one registered output stage.
`timescale 1ns/1ps
module priority_egress_scheduler #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned CW         = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic [3:0]            in_priority,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [3:0]            out_priority,
  input  logic                  out_ready,
  output logic [4*CW-1:0]       occupancy,
  output logic [31:0]           pkt_sent,
  output logic [15:0]           malformed_cnt
);

  localparam int unsigned NCLS = 4;
  localparam int unsigned PW   = $clog2(DEPTH);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  logic [DATA_WIDTH-1:0] mem_data [NCLS][DEPTH];
  logic                  mem_sop  [NCLS][DEPTH];
  logic                  mem_eop  [NCLS][DEPTH];
  logic [3:0]            mem_prio [NCLS][DEPTH];
  logic [PW-1:0]         wr_ptr [NCLS];
  logic [PW-1:0]         rd_ptr [NCLS];
  logic [CW-1:0]         cnt    [NCLS];

  logic       in_pkt;
  logic [1:0] lat_class;
  logic [3:0] lat_prio;
  logic [1:0] tgt_class;
  logic       accept, wr_en, wr_sop, malformed;
  logic [3:0] wr_prio;

  state_t     state_q, state_d;
  logic [1:0] lock_class_q, lock_class_d;
  logic [1:0] hi_cls, pop_cls;
  logic       any_ne, pop_en, load_en, head_eop;
  logic [NCLS-1:0] wr_vec, pop_vec;

  // Continuation beats follow the class latched at SOP, whatever priority they carry
  always_comb tgt_class = in_pkt ? lat_class : in_priority[3:2];

  assign in_ready = (cnt[tgt_class] < CW'(DEPTH));
  assign accept   = in_valid && in_ready;

  // Ingress framing: orphans are dropped, nested SOPs become continuations
  always_comb begin
    wr_en     = 1'b0;
    wr_sop    = 1'b0;
    wr_prio   = lat_prio;
    malformed = 1'b0;
    if (accept) begin
      if (in_sop && !in_pkt) begin
        wr_en   = 1'b1;
        wr_sop  = 1'b1;
        wr_prio = in_priority;
      end else if (in_pkt) begin
        wr_en     = 1'b1;
        malformed = in_sop;
      end else begin
        malformed = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_pkt        <= 1'b0;
      lat_class     <= 2'd0;
      lat_prio      <= 4'd0;
      malformed_cnt <= 16'd0;
    end else if (accept) begin
      if (in_sop && !in_pkt) begin
        lat_class <= in_priority[3:2];
        lat_prio  <= in_priority;
        in_pkt    <= !in_eop;
      end else if (in_pkt && in_eop) begin
        in_pkt <= 1'b0;
      end
      if (malformed && (malformed_cnt != 16'hFFFF))
        malformed_cnt <= malformed_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && rst_n) begin
      mem_data[tgt_class][wr_ptr[tgt_class]] <= in_data;
      mem_sop [tgt_class][wr_ptr[tgt_class]] <= wr_sop;
      mem_eop [tgt_class][wr_ptr[tgt_class]] <= in_eop;
      mem_prio[tgt_class][wr_ptr[tgt_class]] <= wr_prio;
    end
  end

  // Highest non-empty class: the ascending scan lets the last hit win
  always_comb begin
    hi_cls = 2'd0;
    any_ne = 1'b0;
    for (int c = 0; c < NCLS; c++) begin
      if (cnt[c] != '0) begin
        hi_cls = 2'(c);
        any_ne = 1'b1;
      end
    end
  end

  assign load_en  = !out_valid || out_ready;
  assign head_eop = mem_eop[pop_cls][rd_ptr[pop_cls]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      lock_class_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      lock_class_q <= lock_class_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    lock_class_d = lock_class_q;
    if (pop_en) begin
      if (state_q == S_IDLE) lock_class_d = pop_cls;
      state_d = head_eop ? S_IDLE : S_LOCKED;
    end
  end

  // While locked only the locked class may pop; an empty locked class is a bubble
  always_comb begin
    pop_en  = 1'b0;
    pop_cls = lock_class_q;
    if (load_en) begin
      case (state_q)
        S_IDLE: begin
          pop_cls = hi_cls;
          pop_en  = any_ne;
        end
        S_LOCKED: pop_en = (cnt[lock_class_q] != '0);
        default:  pop_en = 1'b0;
      endcase
    end
  end

  always_comb begin
    wr_vec  = '0;
    pop_vec = '0;
    if (wr_en)  wr_vec[tgt_class] = 1'b1;
    if (pop_en) pop_vec[pop_cls]  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NCLS; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        cnt[c]    <= '0;
      end
    end else begin
      for (int c = 0; c < NCLS; c++) begin
        if (wr_vec[c])  wr_ptr[c] <= wr_ptr[c] + PW'(1);
        if (pop_vec[c]) rd_ptr[c] <= rd_ptr[c] + PW'(1);
        cnt[c] <= cnt[c] + CW'(wr_vec[c]) - CW'(pop_vec[c]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_sop      <= 1'b0;
      out_eop      <= 1'b0;
      out_data     <= '0;
      out_priority <= 4'd0;
      pkt_sent     <= 32'd0;
    end else begin
      if (load_en) begin
        out_valid <= pop_en;
        if (pop_en) begin
          out_data     <= mem_data[pop_cls][rd_ptr[pop_cls]];
          out_sop      <= mem_sop [pop_cls][rd_ptr[pop_cls]];
          out_eop      <= head_eop;
          out_priority <= mem_prio[pop_cls][rd_ptr[pop_cls]];
        end else begin
          out_sop <= 1'b0;
          out_eop <= 1'b0;
        end
      end
      if (out_valid && out_ready && out_eop) pkt_sent <= pkt_sent + 32'd1;
    end
  end

  always_comb begin
    occupancy = '0;
    for (int c = 0; c < NCLS; c++) occupancy[c*CW +: CW] = cnt[c];
  end

endmodule

// File: tb/tb_priority_egress_scheduler.sv
// Scoreboard bench for priority_egress_scheduler: directed packets push expected egress
// beats into a queue, an independent monitor pops and compares on each output handshake.
`timescale 1ns/1ps
module tb_priority_egress_scheduler;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic [3:0]    in_priority = 4'd0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid, out_sop, out_eop;
  logic [3:0]    out_priority;
  logic          out_ready = 1'b0;
  logic [4*CW-1:0] occupancy;
  logic [31:0]   pkt_sent;
  logic [15:0]   malformed_cnt;

  priority_egress_scheduler #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_priority(in_priority), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_priority(out_priority), .out_ready(out_ready),
    .occupancy(occupancy), .pkt_sent(pkt_sent), .malformed_cnt(malformed_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          s;
    logic          e;
    logic [3:0]    p;
  } beat_t;

  beat_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] d, input logic s, input logic e, input logic [3:0] p);
    beat_t b;
    b = '{d: d, s: s, e: e, p: p};
    exp_q.push_back(b);
  endtask

  // Called at posedge+1; returns at posedge+1 right after the beat is accepted
  task automatic send(input logic [DW-1:0] d, input logic s, input logic e, input logic [3:0] p);
    int n;
    n = 0;
    in_data = d; in_sop = s; in_eop = e; in_priority = p; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  // First beat sent in input cycle 0 must show on the output in cycle 2
  task automatic lat_chk();
    @(negedge clk); chk("lat_cycle0_valid", 64'(out_valid), 64'd0);
    @(negedge clk); chk("lat_cycle1_valid", 64'(out_valid), 64'd0);
    @(negedge clk); chk("lat_cycle2_valid", 64'(out_valid), 64'd1);
    chk("lat_cycle2_sop", 64'(out_sop), 64'd1);
  endtask

  always @(negedge clk) begin
    beat_t got, e;
    if (rst_n && out_valid && out_ready) begin
      got = '{d: out_data, s: out_sop, e: out_eop, p: out_priority};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got %0h with no beat expected", got);
      end else begin
        e = exp_q.pop_front();
        chk("out_beat", 64'(got), 64'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_pkt_sent", 64'(pkt_sent), 64'd0);
    chk("rst_malformed", 64'(malformed_cnt), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 3-beat packet, continuation beats carry a different priority that must be ignored
    sync();
    out_ready = 1'b1;
    push(32'h100, 1'b1, 1'b0, 4'h5);
    push(32'h101, 1'b0, 1'b0, 4'h5);
    push(32'h102, 1'b0, 1'b1, 4'h5);
    fork
      begin
        send(32'h100, 1'b1, 1'b0, 4'h5);
        send(32'h101, 1'b0, 1'b0, 4'h0);
        send(32'h102, 1'b0, 1'b1, 4'hC);
      end
      lat_chk();
    join
    drain();
    chk("pkt_sent_after_first", 64'(pkt_sent), 64'd1);

    // Low packet already in the output register finishes before the high one
    sync();
    out_ready = 1'b0;
    push(32'h200, 1'b1, 1'b0, 4'h1); push(32'h201, 1'b0, 1'b1, 4'h1);
    push(32'h210, 1'b1, 1'b0, 4'hF); push(32'h211, 1'b0, 1'b1, 4'hF);
    send(32'h200, 1'b1, 1'b0, 4'h1); send(32'h201, 1'b0, 1'b1, 4'h1);
    send(32'h210, 1'b1, 1'b0, 4'hF); send(32'h211, 1'b0, 1'b1, 4'hF);
    @(negedge clk);
    chk("contention_occupancy", 64'(occupancy), 64'h10001);
    out_ready = 1'b1;
    drain();
    chk("pkt_sent_contention_a", 64'(pkt_sent), 64'd3);

    sync();
    out_ready = 1'b0;
    push(32'h220, 1'b1, 1'b0, 4'hF); push(32'h221, 1'b0, 1'b1, 4'hF);
    push(32'h230, 1'b1, 1'b0, 4'h1); push(32'h231, 1'b0, 1'b1, 4'h1);
    send(32'h220, 1'b1, 1'b0, 4'hF); send(32'h221, 1'b0, 1'b1, 4'hF);
    send(32'h230, 1'b1, 1'b0, 4'h1); send(32'h231, 1'b0, 1'b1, 4'h1);
    out_ready = 1'b1;
    drain();
    chk("pkt_sent_contention_b", 64'(pkt_sent), 64'd5);

    // Class 2 holds the output; afterwards class 3 overtakes the earlier class 0 packet
    sync();
    out_ready = 1'b0;
    push(32'h240, 1'b1, 1'b0, 4'hA); push(32'h241, 1'b0, 1'b1, 4'hA);
    push(32'h260, 1'b1, 1'b0, 4'hF); push(32'h261, 1'b0, 1'b1, 4'hF);
    push(32'h250, 1'b1, 1'b0, 4'h1); push(32'h251, 1'b0, 1'b1, 4'h1);
    send(32'h240, 1'b1, 1'b0, 4'hA); send(32'h241, 1'b0, 1'b1, 4'hA);
    send(32'h250, 1'b1, 1'b0, 4'h1); send(32'h251, 1'b0, 1'b1, 4'h1);
    send(32'h260, 1'b1, 1'b0, 4'hF); send(32'h261, 1'b0, 1'b1, 4'hF);
    out_ready = 1'b1;
    drain();
    chk("pkt_sent_contention_c", 64'(pkt_sent), 64'd8);

    // Fill class 0: 16 beats queued plus one in the output register
    sync();
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      push(32'h300 + 32'(i), (i == 0), (i == 16), 4'h2);
      send(32'h300 + 32'(i), (i == 0), (i == 16), 4'h2);
    end
    @(negedge clk);
    chk("full_occ0", 64'(occupancy[CW-1:0]), 64'd16);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    sync();
    out_ready = 1'b1;
    sync();
    out_ready = 1'b0;
    @(negedge clk);
    chk("full_in_ready_restored", 64'(in_ready), 64'd1);
    chk("full_occ0_after_pop", 64'(occupancy[CW-1:0]), 64'd15);
    out_ready = 1'b1;
    drain();
    chk("pkt_sent_full", 64'(pkt_sent), 64'd9);

    // Orphan beat is dropped; nested SOP becomes a continuation in the latched class
    sync();
    send(32'h400, 1'b0, 1'b0, 4'h9);
    @(negedge clk);
    chk("orphan_malformed", 64'(malformed_cnt), 64'd1);
    chk("orphan_occupancy", 64'(occupancy), 64'd0);
    @(negedge clk);
    chk("orphan_no_output", 64'(out_valid), 64'd0);
    sync();
    push(32'h401, 1'b1, 1'b0, 4'h6);
    push(32'h402, 1'b0, 1'b0, 4'h6);
    push(32'h403, 1'b0, 1'b1, 4'h6);
    send(32'h401, 1'b1, 1'b0, 4'h6);
    send(32'h402, 1'b1, 1'b0, 4'hE);
    send(32'h403, 1'b0, 1'b1, 4'h0);
    drain();
    chk("nested_malformed", 64'(malformed_cnt), 64'd2);
    chk("pkt_sent_nested", 64'(pkt_sent), 64'd10);

    // Reset after the 2nd beat of a 4-beat packet
    sync();
    out_ready = 1'b0;
    send(32'h500, 1'b1, 1'b0, 4'h8);
    send(32'h501, 1'b0, 1'b0, 4'h8);
    rst_n = 1'b0;
    @(negedge clk);
    chk("pre_reset_occ2", 64'(occupancy[2*CW +: CW]), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_out_sop_eop", 64'({out_sop, out_eop}), 64'd0);
    chk("mid_rst_out_data", 64'(out_data), 64'd0);
    chk("mid_rst_out_priority", 64'(out_priority), 64'd0);
    chk("mid_rst_pkt_sent", 64'(pkt_sent), 64'd0);
    chk("mid_rst_malformed", 64'(malformed_cnt), 64'd0);
    chk("mid_rst_occupancy", 64'(occupancy), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    sync();
    out_ready = 1'b1;
    push(32'h510, 1'b1, 1'b0, 4'h3);
    push(32'h511, 1'b0, 1'b1, 4'h3);
    fork
      begin
        send(32'h510, 1'b1, 1'b0, 4'h3);
        send(32'h511, 1'b0, 1'b1, 4'h3);
      end
      lat_chk();
    join
    drain();
    chk("pkt_sent_after_reset", 64'(pkt_sent), 64'd1);

    repeat (3) @(negedge clk);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/priority_egress_scheduler.md
PRIORITY_EGRESS_SCHEDULER -- requirements
Module: priority_egress_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512: packet beat width in bits.
REQ-002 SHALL have parameter DEPTH, default 16: beats per class queue; must be a power of 2 and at least 4.
REQ-003 SHALL have parameter CW, default $clog2(DEPTH)+1: occupancy counter width.
REQ-004 SHALL have the following ports, one per line (name, direction, width, meaning):
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_data  in  DATA_WIDTH  ingress beat.
- in_valid  in  1  ingress beat valid.
- in_sop  in  1  start of packet.
- in_eop  in  1  end of packet.
- in_priority  in  4  packet priority; sampled on the SOP beat only.
- in_ready  out  1  ingress may accept.
- out_data  out  DATA_WIDTH  egress beat.
- out_valid  out  1  egress beat valid.
- out_sop  out  1  egress start of packet.
- out_eop  out  1  egress end of packet.
- out_priority  out  4  priority of the packet being sent.
- out_ready  in  1  downstream accepts.
- occupancy  out  4*CW  per-class beat counts; class c occupies bits [c*CW +: CW].
- pkt_sent  out  32  completed egress packets.
- malformed_cnt  out  16  ingress framing errors.

Function
REQ-005 Class SHALL equal priority[3:2]. Four classes; class 3 is highest.
REQ-006 Each class SHALL have one FIFO of DEPTH entries. Each entry holds {data, sop, eop, priority[3:0]}.
REQ-007 Ingress accept SHALL be in_valid && in_ready.
REQ-008 Ingress target class SHALL be:
- the latched class when in_pkt=1;
- otherwise in_priority[3:2].
REQ-009 in_ready SHALL be 1 exactly when occupancy[target] < DEPTH. It is combinational from registered counts and in_pkt/in_priority.
REQ-010 Accepted SOP with in_pkt=0:
- latch class and priority;
- set in_pkt=1 unless eop is also set;
- write the beat.
REQ-011 Accepted non-SOP beat with in_pkt=1:
- write the beat, tagged with the latched priority;
- on eop, clear in_pkt.
REQ-012 Accepted non-SOP beat with in_pkt=0 (orphan): discard the beat and increment malformed_cnt.
REQ-013 Accepted SOP with in_pkt=1 (nested SOP):
- increment malformed_cnt;
- write the beat with sop forced 0, as a continuation into the latched class.
REQ-014 malformed_cnt SHALL saturate at 16'hFFFF.
REQ-015 Output register SHALL load when load_en = !out_valid || out_ready.
REQ-016 Scheduler states SHALL be IDLE and LOCKED (with lock_class register).
REQ-017 IDLE with load_en:
- pick the highest non-empty class, pop its head, load the output;
- stay IDLE if the head has eop, else go LOCKED on that class;
- if all classes are empty, out_valid=0.
REQ-018 LOCKED with load_en:
- if lock_class is non-empty, pop and load; on eop return to IDLE;
- if lock_class is empty, out_valid=0 (bubble) and stay LOCKED.
REQ-019 No class switch SHALL occur mid-packet. Higher classes wait for the EOP.
REQ-020 When load_en=0, the output and all FIFO heads SHALL hold.
REQ-021 Latency SHALL be 2 cycles. A beat accepted at cycle N into an idle, empty scheduler presents out_valid at cycle N+2.
REQ-022 Simultaneous write and pop on the same class SHALL leave its occupancy unchanged. Pointers SHALL wrap modulo DEPTH.
REQ-023 pkt_sent SHALL increment on out_valid && out_ready && out_eop, wrapping at 2^32.

Reset
REQ-024 On rst_n=0 at a clock edge, reset SHALL apply immediately, including mid-packet. It SHALL set:
- all FIFOs empty; occupancy=0;
- state IDLE; in_pkt=0;
- out_valid, out_sop, out_eop = 0;
- out_data=0; out_priority=0;
- pkt_sent=0; malformed_cnt=0.
In-flight beats SHALL be discarded.
REQ-025 in_ready SHALL be 1 during and after reset, since all counts are 0.

Verification
REQ-026 3-beat packet, priority 4'h5, out_ready=1:
- input beats at cycles 0–2; out_valid at cycles 2–4;
- sop on the first output beat, eop on the last, out_priority=5;
- pkt_sent=1.
REQ-027 Contention, with out_ready=0:
- load a 2-beat packet at priority 4'h1, then a 2-beat packet at priority 4'hF;
- raise out_ready: the 4'h1 packet is already in the output register, so it finishes first, then the 4'hF packet;
- repeat with priority 4'h1 loaded second: the 4'hF packet precedes it.
REQ-028 Full: hold out_ready=0 and stream 17 beats of one class-0 packet:
- occupancy[0] reaches 16 and in_ready drops (one beat sits in the output register);
- one handshake restores in_ready within 1 cycle.
REQ-029 Framing errors:
- an orphan beat is discarded, occupancy is unchanged, malformed_cnt=1;
- a nested SOP is stored as a continuation, and the output shows a single sop;
- malformed_cnt=2.
REQ-030 Mid-packet reset:
- assert rst_n=0 for 1 cycle after the 2nd beat of a 4-beat packet;
- all outputs and counters are 0 and occupancy=0;
- a new packet afterwards egresses normally with latency 2.
